nx1_wb_arbiter: RTL and testbench

- Two-requester Wishbone arbiter that shares the single Wishbone slave port of the Neuromorphic_X1_wb core.
- Requester 0 is the management-SoC Wishbone bus; requester 1 is an on-chip test/pattern engine.
- Provides round-robin grant, per-transaction timeout with error return, and a sticky timeout status bit.
- Sits in user_project_wrapper between the requesters and the core instance.

---
 rtl/nx1_wb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_nx1_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx1_wb_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of the Neuromorphic_X1_wb slave port, with per-transaction timeout.
// Latency: request seen in IDLE at cycle N drives m_stb_o from N+1; m_ack_i is forwarded combinationally; one idle cycle between grants.
// Backpressure: a non-granted requester's strobe is simply stalled (no ack/err) until it wins arbitration; nothing is dropped.
module nx1_wb_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024   // 2..65535, fits the 16-bit timeout counter
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    // requester 0: management-SoC Wishbone bus
    input  logic              r0_cyc_i,
    input  logic              r0_stb_i,
    input  logic              r0_we_i,
    input  logic [DW/8-1:0]   r0_sel_i,
    input  logic [AW-1:0]     r0_adr_i,
    input  logic [DW-1:0]     r0_dat_i,
    output logic [DW-1:0]     r0_dat_o,
    output logic              r0_ack_o,
    output logic              r0_err_o,

    // requester 1: on-chip test/pattern engine
    input  logic              r1_cyc_i,
    input  logic              r1_stb_i,
    input  logic              r1_we_i,
    input  logic [DW/8-1:0]   r1_sel_i,
    input  logic [AW-1:0]     r1_adr_i,
    input  logic [DW-1:0]     r1_dat_i,
    output logic [DW-1:0]     r1_dat_o,
    output logic              r1_ack_o,
    output logic              r1_err_o,

    // shared slave port of the core
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [DW/8-1:0]   m_sel_o,
    output logic [AW-1:0]     m_adr_o,
    output logic [DW-1:0]     m_dat_o,
    input  logic [DW-1:0]     m_dat_i,
    input  logic              m_ack_i,

    // sticky timeout status
    output logic              to_flag_o,
    input  logic              to_clr_i
);

    localparam int SW = DW / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Request-side bundle of one Wishbone master, muxed as a unit.
    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        last_grant_nxt;
    logic [15:0] to_cnt;
    logic [15:0] to_cnt_nxt;

    wb_req_t     r0_req;
    wb_req_t     r1_req;
    wb_req_t     gnt_req;

    logic        req0;
    logic        req1;
    logic        to_hit;     // last allowed granted cycle: bus is released regardless
    logic        term_ack;   // granted transfer completes normally
    logic        to_evt;     // granted transfer aborted by timeout (ack beats it)

    assign r0_req = {r0_cyc_i, r0_stb_i, r0_we_i, r0_sel_i, r0_adr_i, r0_dat_i};
    assign r1_req = {r1_cyc_i, r1_stb_i, r1_we_i, r1_sel_i, r1_adr_i, r1_dat_i};

    assign req0 = r0_cyc_i & r0_stb_i;
    assign req1 = r1_cyc_i & r1_stb_i;

    // Select the granted master's bundle; nothing is driven in IDLE or while reset is held.
    always_comb begin
        gnt_req = '0;
        if (!wb_rst_i) begin
            case (state)
                GNT0:    gnt_req = r0_req;
                GNT1:    gnt_req = r1_req;
                default: gnt_req = '0;
            endcase
        end
    end

    // to_hit deliberately ignores m_ack_i so the core's ack never feeds back into m_stb_o.
    assign to_hit   = (state != IDLE) && !wb_rst_i && (to_cnt == TO_LAST);
    assign term_ack = gnt_req.cyc & m_ack_i;
    assign to_evt   = to_hit & gnt_req.cyc & ~m_ack_i;

    // Drive the core port from the granted bundle and route terminations back to the owner only.
    always_comb begin
        m_cyc_o  = gnt_req.cyc & ~to_hit;
        m_stb_o  = gnt_req.stb & ~to_hit;
        m_we_o   = gnt_req.we;
        m_sel_o  = gnt_req.sel;
        m_adr_o  = gnt_req.adr;
        m_dat_o  = gnt_req.dat;

        r0_ack_o = 1'b0;
        r0_err_o = 1'b0;
        r0_dat_o = '0;
        r1_ack_o = 1'b0;
        r1_err_o = 1'b0;
        r1_dat_o = '0;

        if (!wb_rst_i) begin
            if (state == GNT0) begin
                r0_ack_o = term_ack;
                r0_err_o = to_evt;
                r0_dat_o = m_dat_i;
            end
            if (state == GNT1) begin
                r1_ack_o = term_ack;
                r1_err_o = to_evt;
                r1_dat_o = m_dat_i;
            end
        end
    end

    // Round-robin grant from IDLE; every grant is released after one ack, abort or timeout.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        to_cnt_nxt     = to_cnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant)) begin
                    state_nxt      = GNT0;
                    last_grant_nxt = 1'b0;
                    to_cnt_nxt     = '0;
                end else if (req1) begin
                    state_nxt      = GNT1;
                    last_grant_nxt = 1'b1;
                    to_cnt_nxt     = '0;
                end
            end
            GNT0, GNT1: begin
                if (!gnt_req.cyc || term_ack || to_evt) begin
                    state_nxt = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbiter state, round-robin pointer and timeout counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            to_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            to_cnt     <= to_cnt_nxt;
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as a clear keeps it set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_flag_o <= 1'b0;
        end else if (to_evt) begin
            to_flag_o <= 1'b1;
        end else if (to_clr_i) begin
            to_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nx1_wb_arbiter.sv
// Directed bench for nx1_wb_arbiter: scoreboard of expected terminations plus point checks on the core port.
// Latency: each step evaluates the core model, then samples outputs, then waits for the next clock edge.
// Backpressure: requesters hold cyc/stb until the bench releases them; the core model acks after a programmable delay or never.
module tb_nx1_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic            r0_cyc, r0_stb, r0_we;
    logic [3:0]      r0_sel;
    logic [31:0]     r0_adr, r0_wdat;
    logic [31:0]     r0_rdat;
    logic            r0_ack, r0_err;
    logic            r1_cyc, r1_stb, r1_we;
    logic [3:0]      r1_sel;
    logic [31:0]     r1_adr, r1_wdat;
    logic [31:0]     r1_rdat;
    logic            r1_ack, r1_err;
    logic            m_cyc, m_stb, m_we;
    logic [3:0]      m_sel;
    logic [31:0]     m_adr, m_wdat, m_rdat;
    logic            m_ack;
    logic            to_flag, to_clr;

    nx1_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .r0_cyc_i (r0_cyc), .r0_stb_i (r0_stb), .r0_we_i (r0_we),
        .r0_sel_i (r0_sel), .r0_adr_i (r0_adr), .r0_dat_i (r0_wdat),
        .r0_dat_o (r0_rdat), .r0_ack_o (r0_ack), .r0_err_o (r0_err),
        .r1_cyc_i (r1_cyc), .r1_stb_i (r1_stb), .r1_we_i (r1_we),
        .r1_sel_i (r1_sel), .r1_adr_i (r1_adr), .r1_dat_i (r1_wdat),
        .r1_dat_o (r1_rdat), .r1_ack_o (r1_ack), .r1_err_o (r1_err),
        .m_cyc_o  (m_cyc),  .m_stb_o  (m_stb),  .m_we_o   (m_we),
        .m_sel_o  (m_sel),  .m_adr_o  (m_adr),  .m_dat_o  (m_wdat),
        .m_dat_i  (m_rdat), .m_ack_i  (m_ack),
        .to_flag_o(to_flag), .to_clr_i (to_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          req;
        bit          is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          n_acks     = 0;

    // core model state
    int          ack_lat  = -1;     // cycles after strobe rises; -1 = never
    logic [31:0] data_off = '0;
    bit          force_ack = 1'b0;
    bit          busy      = 1'b0;
    int          core_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int req, input bit is_err, input logic [31:0] dat);
        exp_t e;
        e.req = req; e.is_err = is_err; e.dat = dat;
        sb.push_back(e);
    endtask

    // Registered-ack slave: the ack decision depends only on how long the transfer has been pending.
    task automatic core_step();
        if (busy) begin
            m_ack = (ack_lat >= 0) && (core_cnt == ack_lat);
        end else if (m_stb === 1'b1) begin
            busy     = 1'b1;
            core_cnt = 0;
            m_ack    = (ack_lat == 0);
        end else begin
            m_ack = 1'b0;
        end
        m_rdat = m_adr + data_off;
        if (m_ack) busy = 1'b0;
        else if (busy && m_cyc !== 1'b1) busy = 1'b0;
        else if (busy) core_cnt++;
        m_ack = m_ack | force_ack;
    endtask

    task automatic monitor();
        logic [1:0]  ack, err;
        logic [31:0] dat [2];
        exp_t        e;
        ack    = {r1_ack, r0_ack};
        err    = {r1_err, r0_err};
        dat[0] = r0_rdat;
        dat[1] = r1_rdat;
        for (int k = 0; k < 2; k++) begin
            if (ack[k] === 1'b1 || err[k] === 1'b1) begin
                chk($sformatf("r%0d_ack_err_excl", k), ack[k] & err[k], 0);
                chk($sformatf("r%0d_idle_dat", 1 - k), dat[1-k], 0);
                if (ack[k] === 1'b1) n_acks++;
                if (sb.size() == 0) begin
                    chk($sformatf("r%0d_unexpected_term", k), {ack[k], err[k]}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("term_req", k, e.req);
                    chk("term_is_err", err[k], e.is_err);
                    if (!e.is_err) chk("term_dat", dat[k], e.dat);
                end
            end
        end
    endtask

    task automatic eval();
        #1 core_step();
        #1 monitor();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            eval();
            next();
        end
    endtask

    initial begin
        rst = 1'b1; to_clr = 1'b0; m_ack = 1'b0; m_rdat = '0;
        r0_cyc = 1'b1; r0_stb = 1'b1; r0_we = 1'b0; r0_sel = 4'hF; r0_adr = 32'h0000_0100; r0_wdat = '0;
        r1_cyc = 1'b1; r1_stb = 1'b1; r1_we = 1'b0; r1_sel = 4'hF; r1_adr = 32'h0000_0200; r1_wdat = '0;

        // reset state while both requesters are already asking
        run(2);
        eval();
        chk("rst_m_cyc", m_cyc, 0);
        chk("rst_m_stb", m_stb, 0);
        chk("rst_m_adr", m_adr, 0);
        chk("rst_acks", {r1_ack, r0_ack, r1_err, r0_err}, 0);
        chk("rst_r0_dat", r0_rdat, 0);
        chk("rst_to_flag", to_flag, 0);
        next();

        // continuous contention, immediate ack: order 0,1,0,1
        rst = 1'b0; ack_lat = 0; data_off = '0;
        push(0, 0, 32'h0000_0100); push(1, 0, 32'h0000_0200);
        push(0, 0, 32'h0000_0100); push(1, 0, 32'h0000_0200);
        run(8);
        r0_cyc = 0; r0_stb = 0; r1_cyc = 0; r1_stb = 0;
        eval();
        chk("rr_ack_count", n_acks, 4);
        chk("rr_sb_empty", sb.size(), 0);
        next();

        // single read by r0, core acks 3 cycles after strobe
        ack_lat = 3; data_off = 32'hA5A5_0001 - 32'h3000_0004;
        r0_cyc = 1; r0_stb = 1; r0_we = 0; r0_adr = 32'h3000_0004;
        push(0, 0, 32'hA5A5_0001);
        eval();
        chk("rd_stb_idle", m_stb, 0);
        next();
        eval();
        chk("rd_stb_rise", m_stb, 1);
        chk("rd_adr", m_adr, 32'h3000_0004);
        chk("rd_we", m_we, 0);
        next();
        run(2);
        eval();
        chk("rd_ack", r0_ack, 1);
        chk("rd_dat", r0_rdat, 32'hA5A5_0001);
        next();
        r0_cyc = 0; r0_stb = 0;
        eval();
        chk("rd_released", m_cyc, 0);
        next();

        // r1 write, core never acks: timeout after 16 granted cycles
        ack_lat = -1;
        r1_cyc = 1; r1_stb = 1; r1_we = 1; r1_sel = 4'h3; r1_adr = 32'h3000_0010; r1_wdat = 32'hCAFE_0042;
        push(1, 1, '0);
        eval(); next();
        eval();
        chk("wr_m_we", m_we, 1);
        chk("wr_m_dat", m_wdat, 32'hCAFE_0042);
        chk("wr_m_sel", m_sel, 4'h3);
        next();
        run(14);
        eval();
        chk("to_err", r1_err, 1);
        chk("to_m_cyc", m_cyc, 0);
        chk("to_m_stb", m_stb, 0);
        next();
        r1_cyc = 0; r1_stb = 0; r1_we = 0;
        eval();
        chk("to_flag_set", to_flag, 1);
        next();
        to_clr = 1;
        eval(); next();
        to_clr = 0;
        eval();
        chk("to_flag_clr", to_flag, 0);
        next();

        // ack on the 16th granted cycle beats the timeout
        ack_lat = 15; data_off = 32'h0000_1111;
        r0_cyc = 1; r0_stb = 1; r0_adr = 32'h3000_0020;
        push(0, 0, 32'h3000_1131);
        eval(); next();
        run(15);
        eval();
        chk("late_ack", r0_ack, 1);
        chk("late_no_err", r0_err, 0);
        next();
        r0_cyc = 0; r0_stb = 0;
        eval();
        chk("late_flag", to_flag, 0);
        next();

        // r0 aborts with r1 waiting; r1 then granted
        ack_lat = -1;
        r0_cyc = 1; r0_stb = 1; r0_adr = 32'h3000_0030;
        eval(); next();
        r1_cyc = 1; r1_stb = 1; r1_adr = 32'h3000_0040;
        eval();
        chk("ab_gnt0_cyc", m_cyc, 1);
        chk("ab_gnt0_adr", m_adr, 32'h3000_0030);
        next();
        run(1);
        r0_cyc = 0; r0_stb = 0;
        eval();
        chk("ab_cyc_drop", m_cyc, 0);
        next();
        run(1);
        eval();
        chk("ab_gnt1_cyc", m_cyc, 1);
        chk("ab_gnt1_adr", m_adr, 32'h3000_0040);
        next();

        // reset while r1 waits for an ack, then a stray ack
        run(1);
        rst = 1; r1_cyc = 0; r1_stb = 0;
        eval(); next();
        rst = 0;
        eval();
        chk("mrst_m_ctl", {m_cyc, m_stb, m_we}, 0);
        chk("mrst_m_sel", m_sel, 0);
        chk("mrst_m_adr", m_adr, 0);
        chk("mrst_m_dat", m_wdat, 0);
        chk("mrst_flag", to_flag, 0);
        next();
        force_ack = 1;
        eval();
        chk("stray_ack", {r1_ack, r0_ack}, 0);
        next();
        force_ack = 0;
        run(2);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
